// File: rtl/window_fetch_buffer.sv
// Fetches 3x3 pixel windows one read at a time, driving the address counter's increment
// request and handing each completed window to the compute stage with valid/ack.
module window_fetch_buffer #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_start,
  input  logic [15:0]          i_img_width,
  input  logic [15:0]          i_img_height,
  output logic                 o_inc_raddr,
  input  logic                 i_r_ready,
  input  logic [ADDR_W-1:0]    i_raddr,
  output logic                 o_mem_req,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic [PIXEL_W-1:0]   i_mem_rdata,
  output logic                 o_window_valid,
  output logic [9*PIXEL_W-1:0] o_window,
  input  logic                 i_window_ack,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  typedef enum logic [2:0] {StIdle, StReqAddr, StWaitAddr, StMemRd, StWinOut} state_e;

  state_e               state_q, state_d;
  logic [3:0]           pix_cnt_q, pix_cnt_d;
  logic [31:0]          win_cnt_q, win_cnt_d;
  logic [31:0]          total_q, total_d;
  logic                 inc_q, inc_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [9*PIXEL_W-1:0] window_q, window_d;

  logic [31:0] total_new;
  logic        too_small;

  assign total_new = 32'(i_img_width - 16'd2) * 32'(i_img_height - 16'd2);
  assign too_small = (i_img_width < 16'd3) || (i_img_height < 16'd3);

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    win_cnt_d = win_cnt_q;
    total_d   = total_q;
    inc_d     = 1'b0;
    req_d     = req_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    window_d  = window_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          total_d   = total_new;
          pix_cnt_d = 4'd0;
          win_cnt_d = 32'd0;
          if (too_small) begin
            done_d = 1'b1;
          end else begin
            // First pixel of a frame uses the counter's reset address, no increment.
            busy_d  = 1'b1;
            addr_d  = i_raddr;
            req_d   = 1'b1;
            state_d = StMemRd;
          end
        end
      end
      StReqAddr: begin
        state_d = StWaitAddr;
      end
      StWaitAddr: begin
        if (i_r_ready) begin
          addr_d  = i_raddr;
          req_d   = 1'b1;
          state_d = StMemRd;
        end
      end
      StMemRd: begin
        if (i_mem_ack) begin
          req_d = 1'b0;
          window_d[32'(pix_cnt_q)*PIXEL_W +: PIXEL_W] = i_mem_rdata;
          if (pix_cnt_q == 4'd8) begin
            valid_d = 1'b1;
            state_d = StWinOut;
          end else begin
            pix_cnt_d = pix_cnt_q + 4'd1;
            inc_d     = 1'b1;
            state_d   = StReqAddr;
          end
        end
      end
      StWinOut: begin
        if (i_window_ack) begin
          valid_d   = 1'b0;
          win_cnt_d = win_cnt_q + 32'd1;
          if (win_cnt_q + 32'd1 == total_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            pix_cnt_d = 4'd0;
            inc_d     = 1'b1;
            state_d   = StReqAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      pix_cnt_q <= 4'd0;
      win_cnt_q <= 32'd0;
      total_q   <= 32'd0;
      inc_q     <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      window_q  <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      win_cnt_q <= win_cnt_d;
      total_q   <= total_d;
      inc_q     <= inc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      window_q  <= window_d;
    end
  end

  assign o_inc_raddr    = inc_q;
  assign o_mem_req      = req_q;
  assign o_mem_addr     = addr_q;
  assign o_window_valid = valid_q;
  assign o_window       = window_q;
  assign o_busy         = busy_q;
  assign o_frame_done   = done_q;

endmodule

// File: tb/tb_window_fetch_buffer.sv
// Random-latency bench for window_fetch_buffer: counter and memory responders plus a
// sequential-address model of which pixels each window must contain.
module tb_window_fetch_buffer;
  localparam int unsigned PW = 8;
  localparam int unsigned AW = 32;
  localparam logic [31:0] BASE = 32'h0000_10F8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [15:0]   i_img_width = 16'd0;
  logic [15:0]   i_img_height = 16'd0;
  logic          o_inc_raddr;
  logic          i_r_ready;
  logic [AW-1:0] raddr = BASE;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_ack;
  logic [PW-1:0] mem_rdata = '0;
  logic          o_window_valid;
  logic [9*PW-1:0] o_window;
  logic          i_window_ack = 1'b0;
  logic          o_busy;
  logic          o_frame_done;

  logic rr_model = 1'b0, spur_rr = 1'b0, ack_model = 1'b0, spur_ack = 1'b0;
  assign i_r_ready = rr_model | spur_rr;
  assign i_mem_ack = ack_model | spur_ack;

  int errors = 0;
  int checks = 0;
  int mem_max = 0;
  int inc_cnt = 0, req_rise = 0, done_cnt = 0;

  always #5 clk = ~clk;

  window_fetch_buffer #(.PIXEL_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_img_width(i_img_width),
    .i_img_height(i_img_height), .o_inc_raddr(o_inc_raddr), .i_r_ready(i_r_ready),
    .i_raddr(raddr), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(mem_rdata), .o_window_valid(o_window_valid), .o_window(o_window),
    .i_window_ack(i_window_ack), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [31:0] a);
    return a[7:0];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Address counter: advances on each increment pulse, reports after 1..3 cycles.
  initial begin
    int rr_wait;
    rr_wait = -1;
    forever begin
      @(posedge clk);
      #1;
      if (!n_rst) begin
        raddr = BASE;
        rr_model = 1'b0;
        rr_wait = -1;
      end else begin
        rr_model = 1'b0;
        if (rr_wait == 0) begin
          rr_model = 1'b1;
          rr_wait = -1;
        end else if (rr_wait > 0) begin
          rr_wait--;
        end
        if (o_inc_raddr) begin
          raddr = raddr + 32'd1;
          rr_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  // Memory: acks after a random delay; address must hold while the request is pending.
  initial begin
    int mem_wait;
    logic [31:0] held_addr;
    mem_wait = -1;
    held_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      ack_model = 1'b0;
      if (!n_rst) begin
        mem_wait = -1;
      end else if (o_mem_req) begin
        if (mem_wait < 0) begin
          mem_wait = $urandom_range(0, mem_max);
          held_addr = o_mem_addr;
        end else begin
          check("mem_addr_stable", o_mem_addr, held_addr);
        end
        if (mem_wait == 0) begin
          ack_model = 1'b1;
          mem_rdata = pix_of(o_mem_addr);
          mem_wait = -1;
        end else begin
          mem_wait--;
        end
      end
    end
  end

  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_inc_raddr) inc_cnt++;
      if (o_mem_req && !req_prev) req_rise++;
      if (o_frame_done) done_cnt++;
      req_prev = o_mem_req;
    end
  end

  task automatic check_cleared(input string tag);
    check(tag, {o_busy, o_inc_raddr, o_mem_req, o_window_valid, o_frame_done, o_mem_addr,
                o_window}, '0);
  endtask

  // ack_dly < 0 picks a random 0..3 cycle consumer delay per window.
  task automatic run_frame(input int w, input int h, input int ack_dly, input bit spurious);
    logic [31:0] fbase;
    logic [71:0] expw;
    int t, i0, r0, d0, i1, r1, dl, waited;
    fbase = raddr;
    t = (w >= 3 && h >= 3) ? (w - 2) * (h - 2) : 0;
    i0 = inc_cnt;
    r0 = req_rise;
    d0 = done_cnt;
    i_img_width = 16'(w);
    i_img_height = 16'(h);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    if (t == 0) begin
      check("small_done_pulse", o_frame_done, 1'b1);
      check("small_busy", o_busy, 1'b0);
      tick(20);
      check("small_no_req", req_rise - r0, 0);
      check("small_no_inc", inc_cnt - i0, 0);
      check("small_done_cnt", done_cnt - d0, 1);
      return;
    end
    check("busy_after_start", o_busy, 1'b1);
    for (int wi = 0; wi < t; wi++) begin
      waited = 0;
      while (!o_window_valid && waited < 3000) begin
        tick();
        waited++;
      end
      if (!o_window_valid) begin
        check("window_timeout", 1'b0, 1'b1);
        return;
      end
      for (int k = 0; k < 9; k++) expw[k*8 +: 8] = pix_of(fbase + 32'(9 * wi + k));
      check("window", o_window, expw);
      i1 = inc_cnt;
      r1 = req_rise;
      dl = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
      for (int j = 0; j < dl; j++) begin
        if (spurious && j == 1) begin
          spur_rr = 1'b1;
          spur_ack = 1'b1;
          i_start = 1'b1;
        end
        tick();
        spur_rr = 1'b0;
        spur_ack = 1'b0;
        i_start = 1'b0;
        check("hold_valid", o_window_valid, 1'b1);
        check("hold_window", o_window, expw);
      end
      check("hold_no_req", req_rise - r1, 0);
      check("hold_no_inc", inc_cnt - i1, 0);
      i_window_ack = 1'b1;
      tick();
      i_window_ack = 1'b0;
      check("valid_drop", o_window_valid, 1'b0);
      if (wi == t - 1) begin
        check("frame_done_pulse", o_frame_done, 1'b1);
        check("busy_end", o_busy, 1'b0);
      end else begin
        check("busy_mid", o_busy, 1'b1);
      end
    end
    tick(3);
    check("frame_done_low", o_frame_done, 1'b0);
    check("inc_count", inc_cnt - i0, 9 * t - 1);
    check("req_count", req_rise - r0, 9 * t);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    tick(3);
    check_cleared("reset_outputs");
    n_rst = 1'b1;
    tick(2);

    mem_max = 0;
    run_frame(4, 4, -1, 1'b0);
    mem_max = 5;
    run_frame(5, 4, 10, 1'b1);
    run_frame(6, 5, -1, 1'b0);
    run_frame(2, 5, -1, 1'b0);
    run_frame(7, 1, -1, 1'b0);

    // Abort a frame part way through with an asynchronous reset.
    i_img_width = 16'd5;
    i_img_height = 16'd5;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(40);
    check("busy_before_reset", o_busy, 1'b1);
    #2 n_rst = 1'b0;
    #1 check_cleared("async_reset");
    tick(2);
    check_cleared("held_reset");
    n_rst = 1'b1;
    tick(2);
    check_cleared("after_reset");
    mem_max = 3;
    run_frame(4, 4, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
